seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_pkg.sv | 36 +++
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/bin_to_7seg_decoder.sv | 10 +
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan path: FSM states, hex segment map
// and the cyclic next-enabled-digit search.
package seg7_scan_driver_pkg;

    typedef enum logic [1:0] {StIdle, StBlank, StShow} seg7_state_e;

    localparam int unsigned MaxDigits = 16;
    typedef logic [3:0] digit_idx_t;

    // Segment order {g,f,e,d,c,b,a}, a = bit 0.
    localparam logic [6:0] HexSegTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // First set bit strictly after idx, wrapping modulo n; returns idx itself if it is
    // the only set bit. Passing idx = n-1 yields the lowest set bit.
    function automatic digit_idx_t next_set_bit(input logic [MaxDigits-1:0] mask,
                                                input digit_idx_t idx,
                                                input int unsigned n);
        digit_idx_t  res;
        logic        found;
        logic [31:0] cand;
        res   = idx;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxDigits; k++) begin
            cand = (32'(idx) + k) % n;
            if (!found && k <= n && mask[cand[3:0]]) begin
                res   = cand[3:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between the register file / ALU and the scan driver.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned PRESCALE_W = 16
);
    logic                    ena;
    logic [4*NUM_DIGITS-1:0] nibbles;
    logic [NUM_DIGITS-1:0]   digit_mask;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [PRESCALE_W-1:0]   divider;
    logic [3:0]              blank_cycles;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_tick;

    modport master (
        output ena, nibbles, digit_mask, dp_mask, divider, blank_cycles,
        input  seg_out, digit_en, frame_tick
    );

    modport slave (
        input  ena, nibbles, digit_mask, dp_mask, divider, blank_cycles,
        output seg_out, digit_en, frame_tick
    );
endinterface

// File: rtl/bin_to_7seg_decoder.sv
// Nibble to {dp,g,f,e,d,c,b,a} segment pattern, active high.
module bin_to_7seg_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);
    assign seg_o = {dp_i, HexSegTable[nibble_i]};
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner: BLANK gap then SHOW on-time per enabled digit,
// with a frame tick on each wrap back to the first enabled digit.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned PRESCALE_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam digit_idx_t            LastIdx = digit_idx_t'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_W-1:0] CntOne  = 1;

    seg7_state_e           state_q, state_d;
    digit_idx_t            idx_q, idx_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] den_q;

    logic [MaxDigits-1:0]  mask_ext;
    logic [PRESCALE_W-1:0] blank_ext;
    digit_idx_t            first_idx, step_idx;
    logic [3:0]            nib_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] onehot_d;
    logic [7:0]            seg_dec;

    assign mask_ext  = MaxDigits'(bus.digit_mask);
    assign blank_ext = PRESCALE_W'(bus.blank_cycles);
    assign first_idx = next_set_bit(mask_ext, LastIdx, NUM_DIGITS);
    assign step_idx  = next_set_bit(mask_ext, idx_q, NUM_DIGITS);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (bus.digit_mask == '0) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    idx_d = first_idx;
                    if (bus.blank_cycles == 4'd0) begin
                        state_d = StShow;
                        cnt_d   = bus.divider;
                    end else begin
                        state_d = StBlank;
                        cnt_d   = '0;
                    end
                end
                // BLANK counts up so the reset entry needs no sampled load of blank_cycles.
                StBlank: begin
                    if ((cnt_q + CntOne) >= blank_ext) begin
                        state_d = StShow;
                        cnt_d   = bus.divider;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StShow: begin
                    if (cnt_q == '0) begin
                        idx_d  = step_idx;
                        tick_d = (step_idx <= idx_q);
                        if (bus.blank_cycles == 4'd0) begin
                            state_d = StShow;
                            cnt_d   = bus.divider;
                        end else begin
                            state_d = StBlank;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Segments are decoded for the digit that will be shown after this edge.
    always_comb begin
        nib_d    = 4'h0;
        dp_d     = 1'b0;
        onehot_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == digit_idx_t'(k)) begin
                nib_d       = bus.nibbles[4*k +: 4];
                dp_d        = bus.dp_mask[k];
                onehot_d[k] = 1'b1;
            end
        end
    end

    bin_to_7seg_decoder u_dec (
        .nibble_i (nib_d),
        .dp_i     (dp_d),
        .seg_o    (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBlank;
            idx_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= '0;
            den_q   <= '0;
            tick_q  <= 1'b0;
        end else if (bus.ena) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= (state_d == StShow) ? seg_dec : 8'h00;
            den_q   <= (state_d == StShow) ? onehot_d : '0;
            tick_q  <= tick_d;
        end else begin
            tick_q  <= 1'b0;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.digit_en   = den_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: per-cycle vector table plus async reset sequence.
module tb_seg7_scan_driver;

    logic clk;
    logic rst_n;

    seg7_scan_driver_if #(.NUM_DIGITS(6), .PRESCALE_W(16)) bus ();

    seg7_scan_driver #(.NUM_DIGITS(6), .PRESCALE_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [5:0]  mask;
        logic [5:0]  dp;
        logic [23:0] nib;
        logic [15:0] div;
        logic [3:0]  blank;
        logic [7:0]  seg;
        logic [5:0]  den;
        logic        tick;
        int          reps;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [23:0] NibA = 24'hFEDCBA;
    localparam logic [23:0] NibB = 24'h080000;
    localparam logic [23:0] NibC = 24'h000050;

    task automatic add(input logic ena, input logic [5:0] mask, input logic [5:0] dp,
                       input logic [23:0] nib, input logic [15:0] div, input logic [3:0] blank,
                       input logic [7:0] seg, input logic [5:0] den, input logic tick,
                       input int reps);
        vec_t v;
        v.ena = ena; v.mask = mask; v.dp = dp; v.nib = nib; v.div = div; v.blank = blank;
        v.seg = seg; v.den = den; v.tick = tick; v.reps = reps;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] seg, input logic [5:0] den,
                              input logic tick);
        check({tag, " seg_out"}, 32'(bus.seg_out), 32'(seg));
        check({tag, " digit_en"}, 32'(bus.digit_en), 32'(den));
        check({tag, " frame_tick"}, 32'(bus.frame_tick), 32'(tick));
    endtask

    task automatic drive(input logic ena, input logic [5:0] mask, input logic [5:0] dp,
                         input logic [23:0] nib, input logic [15:0] div,
                         input logic [3:0] blank);
        bus.ena = ena; bus.digit_mask = mask; bus.dp_mask = dp;
        bus.nibbles = nib; bus.divider = div; bus.blank_cycles = blank;
    endtask

    initial begin
        // Full scan: mask 3F, divider 3, blank 2.
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 1);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h77, 6'h01, 0, 4);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 2);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h7C, 6'h02, 0, 4);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 2);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h39, 6'h04, 0, 4);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 2);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h5E, 6'h08, 0, 4);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 2);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h79, 6'h10, 0, 4);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 2);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h71, 6'h20, 0, 4);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 1, 1);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h00, 6'h00, 0, 1);
        add(1, 6'h3F, 6'h00, NibA, 3, 2, 8'h77, 6'h01, 0, 4);
        // Sparse mask 05 with no blanking.
        add(1, 6'h05, 6'h00, NibA, 3, 0, 8'h39, 6'h04, 0, 4);
        add(1, 6'h05, 6'h00, NibA, 3, 0, 8'h77, 6'h01, 1, 1);
        add(1, 6'h05, 6'h00, NibA, 3, 0, 8'h77, 6'h01, 0, 3);
        add(1, 6'h05, 6'h00, NibA, 3, 0, 8'h39, 6'h04, 0, 4);
        add(1, 6'h05, 6'h00, NibA, 3, 0, 8'h77, 6'h01, 1, 1);
        // Single digit 4 with decimal point; digit 0 finishes its phase with live nibbles.
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'h3F, 6'h01, 0, 3);
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'h00, 6'h00, 0, 1);
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'hFF, 6'h10, 0, 2);
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'h00, 6'h00, 1, 1);
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'hFF, 6'h10, 0, 2);
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'h00, 6'h00, 1, 1);
        // Mask dropped to zero mid-SHOW, then restored to digit 1.
        add(1, 6'h10, 6'h10, NibB, 1, 1, 8'hFF, 6'h10, 0, 1);
        add(1, 6'h00, 6'h10, NibB, 1, 1, 8'h00, 6'h00, 0, 2);
        add(1, 6'h02, 6'h10, NibB, 1, 1, 8'h00, 6'h00, 0, 1);
        add(1, 6'h02, 6'h10, NibB, 1, 1, 8'h3F, 6'h02, 0, 2);
        // Freeze mid-SHOW (nibble change hidden), resume, then freeze over a tick.
        add(1, 6'h02, 6'h10, NibB, 4, 1, 8'h00, 6'h00, 1, 1);
        add(1, 6'h02, 6'h10, NibB, 4, 1, 8'h3F, 6'h02, 0, 2);
        add(0, 6'h02, 6'h10, NibC, 4, 1, 8'h3F, 6'h02, 0, 10);
        add(1, 6'h02, 6'h10, NibC, 4, 1, 8'h6D, 6'h02, 0, 3);
        add(1, 6'h02, 6'h10, NibC, 4, 1, 8'h00, 6'h00, 1, 1);
        add(0, 6'h02, 6'h10, NibC, 4, 1, 8'h00, 6'h00, 0, 2);
        add(1, 6'h02, 6'h10, NibC, 4, 1, 8'h6D, 6'h02, 0, 1);

        rst_n = 1'b0;
        drive(1, 6'h3F, 6'h00, NibA, 3, 2);
        repeat (2) @(negedge clk);
        check_outs("reset", 8'h00, 6'h00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].ena, vecs[i].mask, vecs[i].dp, vecs[i].nib, vecs[i].div,
                      vecs[i].blank);
                @(negedge clk);
                check_outs($sformatf("vec%0d.%0d", i, r), vecs[i].seg, vecs[i].den,
                           vecs[i].tick);
            end
        end

        // Asynchronous reset while digit 1 is lit; scan must restart at digit 0.
        drive(1, 6'h3F, 6'h00, NibA, 3, 2);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 8'h00, 6'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("restart_blank", 8'h00, 6'h00, 1'b0);
        @(negedge clk);
        check_outs("restart_d0", 8'h77, 6'h01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
